// File: rtl/tinymips_param_core.sv
// tinymips_param_core: parametrised multicycle TinyMIPS with one unified memory port.
// Talks directly to a registered block RAM (read data valid one cycle after the address).
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   data_fromRAM RAM read data (DW bits); fetch uses only bits [15:0]
//   wrEn         RAM write enable, high only in the SW execute cycle
//   addr_toRAM   RAM address (AW bits)
//   data_toRAM   RAM write data (DW bits)
//   halted       high while the core sits in HALT
module tinymips_param_core #(
    parameter int unsigned   DW       = 16,
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_fromRAM,
    output logic          wrEn,
    output logic [AW-1:0] addr_toRAM,
    output logic [DW-1:0] data_toRAM,
    output logic          halted
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMemrd, StHalt} state_e;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpAddi = 4'h1;
    localparam logic [3:0] OpNand = 4'h2;
    localparam logic [3:0] OpLw   = 4'h4;
    localparam logic [3:0] OpSw   = 4'h5;
    localparam logic [3:0] OpCpi  = 4'h7;
    localparam logic [3:0] OpBeq  = 4'h8;
    localparam logic [3:0] OpBlt  = 4'h9;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e        st_q, st_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   iw_q, iw_d;
    logic [DW-1:0] t1_q, t1_d;
    logic [DW-1:0] t2_q, t2_d;
    logic [DW-1:0] rf_q [8];

    logic          rf_we;
    logic [2:0]    rf_wa;
    logic [DW-1:0] rf_wd;

    logic [15:0]   instr;
    logic [3:0]    op;
    logic [DW-1:0] imm6_dw;
    logic [AW-1:0] imm6_aw;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] mem_addr;

    assign instr   = data_fromRAM[15:0];
    assign op      = iw_q[15:12];
    assign imm6_dw = {{(DW-6){iw_q[5]}}, iw_q[5:0]};
    assign imm6_aw = {{(AW-6){iw_q[5]}}, iw_q[5:0]};
    assign pc_inc  = pc_q + AW'(1);
    // Truncating the base before the add gives the same result modulo 2^AW.
    assign mem_addr = ((op == OpLw) ? t1_q[AW-1:0] : t2_q[AW-1:0]) + imm6_aw;

    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        iw_d  = iw_q;
        t1_d  = t1_q;
        t2_d  = t2_q;
        rf_we = 1'b0;
        rf_wa = iw_q[11:9];
        rf_wd = '0;
        case (st_q)
            StFetch: st_d = StDecode;
            StDecode: begin
                iw_d = instr;
                case (instr[15:12])
                    OpCpi: begin
                        rf_we = 1'b1;
                        rf_wa = instr[11:9];
                        rf_wd = {{(DW-9){1'b0}}, instr[8:0]};
                        pc_d  = pc_inc;
                        st_d  = StFetch;
                    end
                    OpHalt: st_d = StHalt;
                    OpAdd, OpAddi, OpNand, OpLw: begin
                        t1_d = rf_q[instr[8:6]];
                        t2_d = rf_q[instr[5:3]];
                        st_d = StExec;
                    end
                    OpSw, OpBeq, OpBlt: begin
                        t1_d = rf_q[instr[11:9]];
                        t2_d = rf_q[instr[8:6]];
                        st_d = StExec;
                    end
                    default: begin
                        pc_d = pc_inc;
                        st_d = StFetch;
                    end
                endcase
            end
            StExec: begin
                st_d = StFetch;
                pc_d = pc_inc;
                case (op)
                    OpAdd: begin
                        rf_we = 1'b1;
                        rf_wd = t1_q + t2_q;
                    end
                    OpAddi: begin
                        rf_we = 1'b1;
                        rf_wd = t1_q + imm6_dw;
                    end
                    OpNand: begin
                        rf_we = 1'b1;
                        rf_wd = ~(t1_q & t2_q);
                    end
                    OpLw: begin
                        st_d = StMemrd;
                        pc_d = pc_q;
                    end
                    OpBeq: if (t1_q == t2_q) pc_d = pc_q + imm6_aw;
                    OpBlt: if (t1_q < t2_q) pc_d = pc_q + imm6_aw;
                    default: ;
                endcase
            end
            StMemrd: begin
                rf_we = 1'b1;
                rf_wd = data_fromRAM;
                pc_d  = pc_inc;
                st_d  = StFetch;
            end
            StHalt: st_d = StHalt;
            default: st_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= StFetch;
            pc_q <= RESET_PC;
            iw_q <= '0;
            t1_q <= '0;
            t2_q <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            st_q <= st_d;
            pc_q <= pc_d;
            iw_q <= iw_d;
            t1_q <= t1_d;
            t2_q <= t2_d;
            if (rf_we) rf_q[rf_wa] <= rf_wd;
        end
    end

    // Outputs are decoded from state only; reset forces them quiet so an
    // aborted store never reaches the RAM.
    always_comb begin
        wrEn       = 1'b0;
        addr_toRAM = '0;
        data_toRAM = '0;
        halted     = 1'b0;
        if (!rst) begin
            case (st_q)
                StFetch: addr_toRAM = pc_q;
                StExec: begin
                    if (op == OpLw) begin
                        addr_toRAM = mem_addr;
                    end else if (op == OpSw) begin
                        wrEn       = 1'b1;
                        addr_toRAM = mem_addr;
                        data_toRAM = t1_q;
                    end
                end
                StHalt: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tinymips_param_core.sv
// Bench for tinymips_param_core: two configurations share one registered RAM model.
// An instruction-level reference model turns each program into the expected per-cycle bus
// trace; a monitor pops and compares that trace against the active core every cycle.
module tb_tinymips_param_core;

    localparam int MemWords = 4096;
    localparam int MaxSteps = 200;

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic        halt;
    } bus_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic cur  = 1'b0;
    logic load = 1'b0;
    logic mon_en = 1'b0;

    logic [31:0] mem [MemWords];
    logic [31:0] img [MemWords];
    logic [31:0] mm  [MemWords];
    logic [31:0] rdata;

    logic        wr0, h0;
    logic [7:0]  addr0;
    logic [15:0] dout0;
    logic        wr1, h1;
    logic [11:0] addr1;
    logic [31:0] dout1;

    bus_t bus;
    bus_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   first_wr;
    logic [31:0] first_wr_addr;
    logic [31:0] pc_w, am_w;

    tinymips_param_core #(.DW(16), .AW(8), .RESET_PC(8'd255)) u16 (
        .clk(clk), .rst(rst0), .data_fromRAM(rdata[15:0]), .wrEn(wr0),
        .addr_toRAM(addr0), .data_toRAM(dout0), .halted(h0)
    );

    tinymips_param_core #(.DW(32), .AW(12), .RESET_PC(12'd0)) u32 (
        .clk(clk), .rst(rst1), .data_fromRAM(rdata), .wrEn(wr1),
        .addr_toRAM(addr1), .data_toRAM(dout1), .halted(h1)
    );

    always_comb bus = cur ? {wr1, addr1, dout1, h1} : {wr0, 4'd0, addr0, 16'd0, dout0, h0};

    // Registered block RAM: one-cycle read latency, write on the clock edge.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < MemWords; i++) mem[i] <= img[i];
        end else begin
            if (bus.wr) mem[bus.addr] <= bus.data;
            rdata <= mem[bus.addr];
        end
    end

    always @(negedge clk) begin
        bus_t e;
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL trace_overrun: bus active with no expected entry");
            end else begin
                e = exp_q.pop_front();
                if (bus !== e) begin
                    errors++;
                    $display("FAIL bus_cycle @%0t: got wr=%0b addr=%0h data=%0h halted=%0b, want wr=%0b addr=%0h data=%0h halted=%0b",
                             $time, bus.wr, bus.addr, bus.data, bus.halt, e.wr, e.addr, e.data, e.halt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic h);
        bus_t e;
        e.wr = wr; e.addr = a[11:0]; e.data = d; e.halt = h;
        exp_q.push_back(e);
    endtask

    // Instruction-set model: executes from a copy of the RAM image and emits the bus
    // activity each instruction must show, one entry per clock.
    task automatic build_trace(input int dw, input int aw, input logic [31:0] pc0);
        logic [31:0] dm, am, pc, ir, a, s6;
        logic [31:0] r [8];
        logic [3:0]  op;
        int ra, rb, rc;
        dm = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
        am = (32'd1 << aw) - 32'd1;
        for (int i = 0; i < MemWords; i++) mm[i] = img[i];
        for (int i = 0; i < 8; i++) r[i] = 0;
        pc = pc0;
        exp_q.delete();
        first_wr = -1;
        first_wr_addr = 0;
        for (int n = 0; n < MaxSteps; n++) begin
            ir = mm[pc];
            op = ir[15:12];
            ra = int'(ir[11:9]); rb = int'(ir[8:6]); rc = int'(ir[5:3]);
            s6 = {{26{ir[5]}}, ir[5:0]};
            push(1'b0, pc, 0, 1'b0);
            push(1'b0, 0, 0, 1'b0);
            case (op)
                4'h7: begin r[ra] = {23'd0, ir[8:0]}; pc = (pc + 1) & am; end
                4'hF: begin repeat (3) push(1'b0, 0, 0, 1'b1); return; end
                4'h0: begin push(1'b0, 0, 0, 1'b0); r[ra] = (r[rb] + r[rc]) & dm; pc = (pc + 1) & am; end
                4'h1: begin push(1'b0, 0, 0, 1'b0); r[ra] = (r[rb] + s6) & dm; pc = (pc + 1) & am; end
                4'h2: begin push(1'b0, 0, 0, 1'b0); r[ra] = ~(r[rb] & r[rc]) & dm; pc = (pc + 1) & am; end
                4'h4: begin
                    a = (r[rb] + s6) & am;
                    push(1'b0, a, 0, 1'b0);
                    push(1'b0, 0, 0, 1'b0);
                    r[ra] = mm[a] & dm;
                    pc = (pc + 1) & am;
                end
                4'h5: begin
                    a = (r[rb] + s6) & am;
                    if (first_wr < 0) begin first_wr = exp_q.size(); first_wr_addr = a; end
                    push(1'b1, a, r[ra], 1'b0);
                    mm[a] = r[ra];
                    pc = (pc + 1) & am;
                end
                4'h8: begin push(1'b0, 0, 0, 1'b0); pc = ((r[ra] == r[rb]) ? pc + s6 : pc + 1) & am; end
                4'h9: begin push(1'b0, 0, 0, 1'b0); pc = ((r[ra] < r[rb]) ? pc + s6 : pc + 1) & am; end
                default: pc = (pc + 1) & am;
            endcase
        end
    endtask

    function automatic logic [15:0] rrr(input int op, input int a, input int b, input int c);
        return {4'(op), 3'(a), 3'(b), 3'(c), 3'b000};
    endfunction

    function automatic logic [15:0] ri(input int op, input int a, input int b, input int imm);
        return {4'(op), 3'(a), 3'(b), 6'(imm)};
    endfunction

    function automatic logic [15:0] cpi(input int a, input int imm);
        return {4'h7, 3'(a), 9'(imm)};
    endfunction

    // Upper halfword is junk: the core must fetch from bits [15:0] only.
    task automatic put(input logic [15:0] w);
        img[pc_w] = {16'($urandom), w};
        pc_w = (pc_w + 1) & am_w;
    endtask

    task automatic setup_begin(input logic k);
        for (int i = 0; i < MemWords; i++) img[i] = $urandom;
        pc_w = k ? 32'd0 : 32'd255;
        am_w = k ? 32'd4095 : 32'd255;
    endtask

    task automatic check_idle(input string name);
        chk(name, {14'd0, bus.wr, bus.halt, 4'd0, bus.addr}, 32'd0);
        chk({name, "_data"}, bus.data, 32'd0);
    endtask

    task automatic run_prog(input logic k, input bit abort);
        cur = k;
        rst0 = 1'b1; rst1 = 1'b1; mon_en = 1'b0;
        load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        build_trace(k ? 32 : 16, k ? 12 : 8, k ? 32'd0 : 32'd255);
        @(posedge clk); #1;
        if (k) rst1 = 1'b0; else rst0 = 1'b0;
        mon_en = 1'b1;
        if (abort && first_wr > 0) begin
            // Reset lands on the SW execute cycle and is held for two edges.
            repeat (first_wr) @(posedge clk);
            #1 mon_en = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
            @(negedge clk); check_idle("rst_sw_cycle");
            @(negedge clk); check_idle("rst_hold");
            chk("aborted_store", mem[first_wr_addr], img[first_wr_addr]);
            build_trace(k ? 32 : 16, k ? 12 : 8, k ? 32'd0 : 32'd255);
            @(posedge clk); #1;
            if (k) rst1 = 1'b0; else rst0 = 1'b0;
            mon_en = 1'b1;
        end
        for (int c = 0; c < 20000 && exp_q.size() != 0; c++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL trace_timeout: %0d entries left, want 0", exp_q.size());
        end
        mon_en = 1'b0;
    endtask

    initial begin
        // 16-bit core from PC 255: reset/CPi, ALU, memory, branches, wrap to 0.
        setup_begin(1'b0);
        put(cpi(1, 5));          put(cpi(2, 300));
        put(rrr(0, 3, 1, 2));    put(ri(1, 4, 3, -6));     put(rrr(2, 5, 1, 1));
        put(cpi(6, 100));        put(ri(5, 1, 6, 3));      put(ri(4, 7, 6, 3));
        put(ri(5, 3, 6, 4));     put(ri(5, 4, 6, 5));      put(ri(5, 5, 6, 6));
        put(ri(5, 7, 6, 7));     put(cpi(1, 3));           put(cpi(2, 9));
        put(ri(9, 1, 2, 2));     put(cpi(5, 0));           put(ri(8, 1, 2, 5));
        put(rrr(2, 3, 0, 0));    put(cpi(4, 1));           put(ri(9, 3, 4, 5));
        put(ri(5, 3, 6, 8));     put(ri(5, 5, 6, 9));      put(16'h3000);
        put(16'hF000);
        run_prog(1'b0, 1'b1);
        chk("sw_r1", mem[103], 32'd5);
        chk("add_305", mem[104], 32'd305);
        chk("addi_299", mem[105], 32'd299);
        chk("nand_fffa", mem[106], 32'hFFFA);
        chk("lw_r7", mem[107], 32'd5);
        chk("nand_ffff", mem[108], 32'hFFFF);
        chk("blt_skip", mem[109], 32'hFFFA);

        // 32-bit core, 12-bit addresses: backward branch wrap, overflow, top address.
        setup_begin(1'b1);
        img[4095] = {16'hABCD, cpi(1, 1)};
        img[64] = 32'hDEAD_BEEF;
        put(ri(8, 1, 0, -1));    put(rrr(2, 2, 0, 0));     put(cpi(3, 1));
        put(rrr(0, 4, 2, 3));    put(ri(5, 2, 2, 0));      put(cpi(5, 64));
        put(ri(5, 4, 5, 0));     put(ri(4, 6, 5, 1));      put(ri(5, 6, 5, 2));
        put(16'hF000);
        run_prog(1'b1, 1'b0);
        chk("sw_top_addr", mem[4095], 32'hFFFF_FFFF);
        chk("add_wrap_zero", mem[64], 32'd0);
        chk("lw_full_width", mem[66], img[65]);

        // Random programs on both cores.
        for (int t = 0; t < 6; t++) begin
            int ops [12] = '{0, 1, 2, 3, 4, 5, 7, 7, 8, 9, 0, 5};
            logic k;
            k = 1'(t % 2);
            setup_begin(k);
            for (int i = 0; i < 4; i++) put(cpi($urandom_range(0, 7), $urandom_range(0, 511)));
            for (int i = 0; i < 40; i++) put({4'(ops[$urandom_range(0, 11)]), 12'($urandom)});
            put(16'hF000);
            run_prog(k, t >= 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
